// File: rtl/dm_cache_ctrl_pkg.sv
// Shared types and defaults for the direct-mapped write-through data cache.
package dm_cache_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      RESP   = 2'd2,
      WRITE  = 2'd3
   } state_t;

   localparam int unsigned DEF_ADDR_W = 12;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_LINES  = 8;
   localparam int unsigned DEF_WORDS  = 4;
   localparam int unsigned DEF_CNT_W  = 16;

   // Tag keeps whatever address bits remain above byte offset, word and index.
   function automatic int unsigned tag_width(input int unsigned addr_w,
                                             input int unsigned lines,
                                             input int unsigned words);
      return addr_w - 2 - $clog2(words) - $clog2(lines);
   endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// CPU-side and memory-side bus of the cache; slave is the cache's view.
interface dm_cache_ctrl_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              stall;
   logic              flush;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic [CNT_W-1:0]  hit_cnt;
   logic [CNT_W-1:0]  miss_cnt;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
      input  cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
      output cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
   );
endinterface

// File: rtl/dm_cache_ctrl_line_ram.sv
// Cache data storage: LINES*WORDS words, asynchronous read, synchronous write.
module dm_cache_ctrl_line_ram #(
   parameter int DEPTH  = 32,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with
// line refill over a req/ack memory handshake and saturating hit/miss counters.
module dm_cache_ctrl
   import dm_cache_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LINES  = DEF_LINES,
   parameter int WORDS  = DEF_WORDS,
   parameter int CNT_W  = DEF_CNT_W
) (
   input logic            clk,
   input logic            rstn,
   dm_cache_ctrl_if.slave bus
);
   localparam int WB    = $clog2(WORDS);
   localparam int LB    = $clog2(LINES);
   localparam int TAG_W = tag_width(ADDR_W, LINES, WORDS);

   logic [WB-1:0]    word_sel;
   logic [LB-1:0]    idx;
   logic [TAG_W-1:0] tag;
   assign word_sel = bus.cpu_addr[2+WB-1:2];
   assign idx      = bus.cpu_addr[2+WB+LB-1:2+WB];
   assign tag      = bus.cpu_addr[ADDR_W-1:2+WB+LB];

   logic unused_offset;
   assign unused_offset = &{1'b0, bus.cpu_addr[1:0]};

   state_t           state, state_nxt;
   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tag_arr [LINES];
   logic [WB-1:0]    cnt;
   logic [CNT_W-1:0] hit_q, miss_q;
   logic             hit;
   logic             last_word;

   logic              ram_we;
   logic [LB+WB-1:0]  ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   // A flush in the same cycle wins over the lookup, so the request sees a miss.
   assign hit       = bus.cpu_req & ~bus.flush & valid[idx] & (tag_arr[idx] == tag);
   assign last_word = (cnt == WB'(WORDS - 1));

   dm_cache_ctrl_line_ram #(
      .DEPTH  (LINES * WORDS),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr ({idx, word_sel}),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus every bus output; memory outputs are pure functions of
   // state, refill counter and the stalled CPU address, so they hold until ack.
   always_comb begin
      state_nxt     = state;
      bus.stall     = 1'b0;
      bus.cpu_rdata = '0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      ram_we        = 1'b0;
      ram_waddr     = {idx, word_sel};
      ram_wdata     = bus.cpu_wdata;
      case (state)
         IDLE: begin
            if (bus.cpu_req) begin
               if (bus.cpu_we) begin
                  bus.stall = 1'b1;
                  ram_we    = hit;
                  state_nxt = WRITE;
               end else if (hit) begin
                  bus.cpu_rdata = ram_rdata;
               end else begin
                  bus.stall = 1'b1;
                  state_nxt = REFILL;
               end
            end
         end
         REFILL: begin
            bus.stall    = 1'b1;
            bus.mem_req  = 1'b1;
            bus.mem_addr = {tag, idx, cnt, 2'b00};
            ram_waddr    = {idx, cnt};
            ram_wdata    = bus.mem_rdata;
            if (bus.mem_ack) begin
               ram_we = 1'b1;
               if (last_word) begin
                  state_nxt = RESP;
               end
            end
         end
         RESP: begin
            bus.cpu_rdata = ram_rdata;
            state_nxt     = IDLE;
         end
         WRITE: begin
            bus.stall     = ~bus.mem_ack;
            bus.mem_req   = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = {bus.cpu_addr[ADDR_W-1:2], 2'b00};
            bus.mem_wdata = bus.cpu_wdata;
            if (bus.mem_ack) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Valid bits: a refilling line stays invalid until its last word lands.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (bus.flush) begin
                  valid <= '0;
               end
               if (bus.cpu_req && !bus.cpu_we && !hit) begin
                  valid[idx] <= 1'b0;
               end
            end
            REFILL: begin
               if (bus.mem_ack) begin
                  cnt <= cnt + 1'b1;
                  if (last_word) begin
                     valid[idx] <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == REFILL && bus.mem_ack && last_word) begin
         tag_arr[idx] <= tag;
      end
   end

   // Every lookup is counted once, on its IDLE cycle; counters stick at all-ones.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else if (state == IDLE && bus.cpu_req) begin
         if (hit) begin
            if (hit_q != '1) hit_q <= hit_q + 1'b1;
         end else begin
            if (miss_q != '1) miss_q <= miss_q + 1'b1;
         end
      end
   end

   assign bus.hit_cnt  = hit_q;
   assign bus.miss_cnt = miss_q;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl with a small handshaking memory model.
module tb_dm_cache_ctrl;
   logic clk;
   logic rstn;
   int   checks;
   int   failures;

   dm_cache_ctrl_if #(.ADDR_W(12), .DATA_W(32), .CNT_W(16)) ifc ();

   dm_cache_ctrl #(
      .ADDR_W (12),
      .DATA_W (32),
      .LINES  (8),
      .WORDS  (4),
      .CNT_W  (16)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] model [1024];
   logic [11:0] log_addr [$];
   logic        log_we   [$];
   logic [31:0] log_data [$];

   // Memory model: acks each request two samples after it appears, logs it.
   initial begin
      int wait_cnt;
      wait_cnt      = 0;
      ifc.mem_ack   = 1'b0;
      ifc.mem_rdata = '0;
      for (int i = 0; i < 1024; i++) model[i] = 32'hC0DE_0000 | (i << 2);
      forever begin
         @(posedge clk);
         #1;
         if (ifc.mem_ack) begin
            ifc.mem_ack = 1'b0;
            wait_cnt    = 0;
         end else if (ifc.mem_req && rstn) begin
            if (wait_cnt == 1) begin
               ifc.mem_ack = 1'b1;
               log_addr.push_back(ifc.mem_addr);
               log_we.push_back(ifc.mem_we);
               log_data.push_back(ifc.mem_wdata);
               if (ifc.mem_we) model[ifc.mem_addr[11:2]] = ifc.mem_wdata;
               else ifc.mem_rdata = model[ifc.mem_addr[11:2]];
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_log(input string tag, input int n, input logic [11:0] addr,
                            input logic we, input logic [31:0] data);
      if (n >= log_addr.size()) begin
         check_output({tag, "_present"}, 32'(log_addr.size()), 32'(n + 1));
      end else begin
         check_output({tag, "_addr"}, 32'(log_addr[n]), 32'(addr));
         check_output({tag, "_we"}, 32'(log_we[n]), 32'(we));
         if (we) check_output({tag, "_data"}, log_data[n], data);
      end
   endtask

   // One CPU access held until stall drops; reports first-cycle stall and read data.
   task automatic apply_stimulus(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                                 output logic first_stall, output logic [31:0] rdata);
      bit done;
      done        = 1'b0;
      first_stall = 1'bx;
      rdata       = 'x;
      @(posedge clk);
      #2;
      ifc.cpu_req   = 1'b1;
      ifc.cpu_we    = we;
      ifc.cpu_addr  = addr;
      ifc.cpu_wdata = wdata;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (i == 0) first_stall = ifc.stall;
         if (!ifc.stall) begin
            rdata = ifc.cpu_rdata;
            done  = 1'b1;
            break;
         end
      end
      check_output("access_done", 32'(done), 32'd1);
      @(posedge clk);
      #2;
      ifc.cpu_req = 1'b0;
      ifc.cpu_we  = 1'b0;
   endtask

   initial begin
      logic        st;
      logic [31:0] rd;
      int          base;
      bit          seen;
      checks        = 0;
      failures      = 0;
      rstn          = 1'b0;
      ifc.cpu_req   = 1'b0;
      ifc.cpu_we    = 1'b0;
      ifc.cpu_addr  = '0;
      ifc.cpu_wdata = '0;
      ifc.flush     = 1'b0;
      #1;
      check_output("rst_stall", 32'(ifc.stall), 32'd0);
      check_output("rst_mem_req", 32'(ifc.mem_req), 32'd0);
      check_output("rst_mem_addr", 32'(ifc.mem_addr), 32'd0);
      check_output("rst_rdata", ifc.cpu_rdata, 32'd0);
      check_output("rst_hit_cnt", 32'(ifc.hit_cnt), 32'd0);
      check_output("rst_miss_cnt", 32'(ifc.miss_cnt), 32'd0);
      repeat (3) @(posedge clk);
      #2 rstn = 1'b1;

      // Cold load miss refills the whole line.
      apply_stimulus(1'b0, 12'h040, 32'h0, st, rd);
      check_output("t1_stall", 32'(st), 32'd1);
      check_output("t1_rdata", rd, 32'hC0DE_0040);
      check_output("t1_nreq", 32'(log_addr.size()), 32'd4);
      check_log("t1_w0", 0, 12'h040, 1'b0, 32'h0);
      check_log("t1_w1", 1, 12'h044, 1'b0, 32'h0);
      check_log("t1_w2", 2, 12'h048, 1'b0, 32'h0);
      check_log("t1_w3", 3, 12'h04C, 1'b0, 32'h0);
      check_output("t1_miss_cnt", 32'(ifc.miss_cnt), 32'd1);
      check_output("t1_hit_cnt", 32'(ifc.hit_cnt), 32'd0);

      apply_stimulus(1'b0, 12'h044, 32'h0, st, rd);
      check_output("t2_stall", 32'(st), 32'd0);
      check_output("t2_rdata", rd, 32'hC0DE_0044);
      check_output("t2_hit_cnt", 32'(ifc.hit_cnt), 32'd1);
      check_output("t2_nreq", 32'(log_addr.size()), 32'd4);

      // Store hit writes through and updates the cached word.
      apply_stimulus(1'b1, 12'h048, 32'hDEAD_BEEF, st, rd);
      check_output("t3_stall", 32'(st), 32'd1);
      check_log("t3_wr", 4, 12'h048, 1'b1, 32'hDEAD_BEEF);
      check_output("t3_hit_cnt", 32'(ifc.hit_cnt), 32'd2);
      apply_stimulus(1'b0, 12'h048, 32'h0, st, rd);
      check_output("t3_ld_stall", 32'(st), 32'd0);
      check_output("t3_ld_rdata", rd, 32'hDEAD_BEEF);
      check_output("t3_ld_hit_cnt", 32'(ifc.hit_cnt), 32'd3);

      // Store miss does not allocate.
      apply_stimulus(1'b1, 12'h100, 32'h1234_5678, st, rd);
      check_log("t4_wr", 5, 12'h100, 1'b1, 32'h1234_5678);
      check_output("t4_miss_cnt", 32'(ifc.miss_cnt), 32'd2);
      apply_stimulus(1'b0, 12'h100, 32'h0, st, rd);
      check_output("t4_ld_stall", 32'(st), 32'd1);
      check_output("t4_ld_rdata", rd, 32'h1234_5678);
      check_log("t4_rd0", 6, 12'h100, 1'b0, 32'h0);
      check_output("t4_miss_cnt2", 32'(ifc.miss_cnt), 32'd3);

      // Conflict on index 4 evicts 0x040.
      apply_stimulus(1'b0, 12'h0C0, 32'h0, st, rd);
      check_output("t5_stall", 32'(st), 32'd1);
      check_output("t5_rdata", rd, 32'hC0DE_00C0);
      apply_stimulus(1'b0, 12'h040, 32'h0, st, rd);
      check_output("t5_reload_stall", 32'(st), 32'd1);
      check_output("t5_reload_rdata", rd, 32'hC0DE_0040);
      check_output("t5_miss_cnt", 32'(ifc.miss_cnt), 32'd5);
      apply_stimulus(1'b0, 12'h048, 32'h0, st, rd);
      check_output("t5_wt_stall", 32'(st), 32'd0);
      check_output("t5_wt_rdata", rd, 32'hDEAD_BEEF);
      check_output("t5_hit_cnt", 32'(ifc.hit_cnt), 32'd4);

      // Reset in the middle of a refill abandons it.
      base = log_addr.size();
      seen = 1'b0;
      @(posedge clk);
      #2;
      ifc.cpu_req  = 1'b1;
      ifc.cpu_we   = 1'b0;
      ifc.cpu_addr = 12'h0C0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (log_addr.size() == base + 2) begin
            seen = 1'b1;
            break;
         end
      end
      check_output("t6_two_acks", 32'(seen), 32'd1);
      @(posedge clk);
      #2;
      rstn        = 1'b0;
      ifc.cpu_req = 1'b0;
      #1;
      check_output("t6_mem_req", 32'(ifc.mem_req), 32'd0);
      check_output("t6_stall", 32'(ifc.stall), 32'd0);
      check_output("t6_miss_cnt", 32'(ifc.miss_cnt), 32'd0);
      check_output("t6_hit_cnt", 32'(ifc.hit_cnt), 32'd0);
      @(posedge clk);
      #2 rstn = 1'b1;
      apply_stimulus(1'b0, 12'h040, 32'h0, st, rd);
      check_output("t6_reload_stall", 32'(st), 32'd1);
      check_output("t6_reload_rdata", rd, 32'hC0DE_0040);
      apply_stimulus(1'b0, 12'h040, 32'h0, st, rd);
      check_output("t6_hit_stall", 32'(st), 32'd0);
      check_output("t6_hit_cnt2", 32'(ifc.hit_cnt), 32'd1);
      @(posedge clk);
      #2 ifc.flush = 1'b1;
      @(posedge clk);
      #2 ifc.flush = 1'b0;
      apply_stimulus(1'b0, 12'h040, 32'h0, st, rd);
      check_output("t6_flush_stall", 32'(st), 32'd1);
      check_output("t6_flush_rdata", rd, 32'hC0DE_0040);
      check_output("t6_flush_miss_cnt", 32'(ifc.miss_cnt), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
